fdiv_mant_seq: RTL and testbench

FDIV_MANT_SEQ -- requirements
Module: fdiv_mant_seq

---
 rtl/fdiv_mant_seq.sv | 177 +++++++++++++++++
 tb/tb_fdiv_mant_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_mant_seq.sv
// Sequential restoring divider for floating-point mantissas.
// Normalizes both operands, runs WIDTH+1 restoring steps, then renormalizes the quotient.
module fdiv_mant_seq #(
  parameter int WIDTH       = 24,
  parameter int WIDTH_LOG_2 = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a_mant,
  input  logic [WIDTH-1:0]       b_mant,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       q_mant,
  output logic                   q_sticky,
  output logic [WIDTH_LOG_2+1:0] exp_adj,
  output logic                   div_zero,
  output logic                   q_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, NORM, DIV, POST, DONE} state_t;

  // Count of leading zeros: 0 when the MSB is set, WIDTH-1 when only bit 0 is set.
  function automatic logic [WIDTH_LOG_2-1:0] lzc(input logic [WIDTH-1:0] v);
    logic [WIDTH_LOG_2-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) n = WIDTH_LOG_2'(WIDTH - 1 - i);
    return n;
  endfunction

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [WIDTH:0]         rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH_LOG_2-1:0] lz_a_q, lz_a_d, lz_b_q, lz_b_d;
  logic                   in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       q_mant_q, q_mant_d;
  logic                   q_sticky_q, q_sticky_d, div_zero_q, div_zero_d, q_zero_q, q_zero_d;
  logic [WIDTH_LOG_2+1:0] exp_adj_q, exp_adj_d;

  logic [WIDTH_LOG_2-1:0] lz_a_c, lz_b_c;
  logic [WIDTH:0]         rem_sel;
  logic                   ge;
  logic [WIDTH_LOG_2+1:0] ediff;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    lz_a_d     = lz_a_q;
    lz_b_d     = lz_b_q;
    q_mant_d   = q_mant_q;
    q_sticky_d = q_sticky_q;
    exp_adj_d  = exp_adj_q;
    div_zero_d = div_zero_q;
    q_zero_d   = q_zero_q;

    lz_a_c  = lzc(a_q);
    lz_b_c  = lzc(b_q);
    ge      = (rem_q >= {1'b0, b_q});
    rem_sel = ge ? (rem_q - {1'b0, b_q}) : rem_q;
    ediff   = {2'b00, lz_b_q} - {2'b00, lz_a_q};

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_d     = a_mant;
            b_d     = b_mant;
            state_d = NORM;
          end
        end
        NORM: begin
          lz_a_d = lz_a_c;
          lz_b_d = lz_b_c;
          if (b_q == '0 || a_q == '0) begin
            div_zero_d = (b_q == '0);
            q_zero_d   = (b_q != '0);
            q_mant_d   = '0;
            q_sticky_d = 1'b0;
            exp_adj_d  = '0;
            state_d    = DONE;
          end else begin
            rem_d   = {1'b0, a_q << lz_a_c};
            b_d     = b_q << lz_b_c;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = DIV;
          end
        end
        DIV: begin
          rem_d = {rem_sel[WIDTH-1:0], 1'b0};
          quo_d = {quo_q[WIDTH-1:0], ge};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH)) state_d = POST;
        end
        POST: begin
          // A leading 1 at weight 2^0 means the quotient is already in [1,2).
          if (quo_q[WIDTH]) begin
            q_mant_d   = quo_q[WIDTH:1];
            q_sticky_d = quo_q[0] | (rem_q != '0);
            exp_adj_d  = ediff;
          end else begin
            q_mant_d   = quo_q[WIDTH-1:0];
            q_sticky_d = (rem_q != '0);
            exp_adj_d  = ediff - 1'b1;
          end
          div_zero_d = 1'b0;
          q_zero_d   = 1'b0;
          state_d    = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      lz_a_q      <= '0;
      lz_b_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_mant_q    <= '0;
      q_sticky_q  <= 1'b0;
      exp_adj_q   <= '0;
      div_zero_q  <= 1'b0;
      q_zero_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      lz_a_q      <= lz_a_d;
      lz_b_q      <= lz_b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      q_mant_q    <= q_mant_d;
      q_sticky_q  <= q_sticky_d;
      exp_adj_q   <= exp_adj_d;
      div_zero_q  <= div_zero_d;
      q_zero_q    <= q_zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q_mant    = q_mant_q;
  assign q_sticky  = q_sticky_q;
  assign exp_adj   = exp_adj_q;
  assign div_zero  = div_zero_q;
  assign q_zero    = q_zero_q;

endmodule

// File: tb/tb_fdiv_mant_seq.sv
// Scoreboard bench for fdiv_mant_seq: a driver pushes hand-computed results,
// a monitor compares whenever out_valid is high.
module tb_fdiv_mant_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] a_mant = '0;
  logic [23:0] b_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] q_mant;
  logic        q_sticky;
  logic [6:0]  exp_adj;
  logic        div_zero;
  logic        q_zero;

  fdiv_mant_seq #(.WIDTH(24), .WIDTH_LOG_2(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_mant(a_mant), .b_mant(b_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .q_mant(q_mant), .q_sticky(q_sticky), .exp_adj(exp_adj),
    .div_zero(div_zero), .q_zero(q_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] q;
    logic        s;
    logic [6:0]  e;
    logic        dz;
    logic        qz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  bit   seen = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  // Monitor: every cycle with out_valid, the presented result must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
        seen = 0;
      end else begin
        mon_e = sb[0];
        if (!seen) begin
          seen = 1;
          checkOutput("latency", 32'(cycle - mon_e.acc), 32'(mon_e.lat));
        end
        checkOutput("q_mant", 32'(q_mant), 32'(mon_e.q));
        checkOutput("q_sticky", 32'(q_sticky), 32'(mon_e.s));
        checkOutput("exp_adj", 32'(exp_adj), 32'(mon_e.e));
        checkOutput("div_zero", 32'(div_zero), 32'(mon_e.dz));
        checkOutput("q_zero", 32'(q_zero), 32'(mon_e.qz));
        checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic issue(input logic [23:0] a, input logic [23:0] b, output int acc);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("issue_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a_mant   = a;
    b_mant   = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc      = cycle;
  endtask

  task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b,
                               input logic [23:0] eq, input logic es, input logic [6:0] ee,
                               input logic edz, input logic eqz, input int lat);
    exp_t e;
    int   acc;
    issue(a, b, acc);
    e.q = eq; e.s = es; e.e = ee; e.dz = edz; e.qz = eqz; e.lat = lat; e.acc = acc;
    sb.push_back(e);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !in_ready) begin
      checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc;
    int n;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_q_mant", 32'(q_mant), 32'd0);
    checkOutput("rst_flags", 32'({q_sticky, div_zero, q_zero}), 32'd0);
    checkOutput("rst_exp_adj", 32'(exp_adj), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed vectors");
    applyStimulus(24'h800000, 24'h800000, 24'h800000, 1'b0, 7'h00, 1'b0, 1'b0, 27); waitIdle();
    applyStimulus(24'h800000, 24'hC00000, 24'hAAAAAA, 1'b1, 7'h7F, 1'b0, 1'b0, 27); waitIdle();
    applyStimulus(24'hC00000, 24'h800000, 24'hC00000, 1'b0, 7'h00, 1'b0, 1'b0, 27); waitIdle();
    applyStimulus(24'h000001, 24'h800000, 24'h800000, 1'b0, 7'h69, 1'b0, 1'b0, 27); waitIdle();
    applyStimulus(24'h800000, 24'h000001, 24'h800000, 1'b0, 7'h17, 1'b0, 1'b0, 27); waitIdle();
    applyStimulus(24'h123456, 24'h000000, 24'h000000, 1'b0, 7'h00, 1'b1, 1'b0, 1);  waitIdle();
    applyStimulus(24'h000000, 24'h900000, 24'h000000, 1'b0, 7'h00, 1'b0, 1'b1, 1);  waitIdle();
    applyStimulus(24'h000000, 24'h000000, 24'h000000, 1'b0, 7'h00, 1'b1, 1'b0, 1);  waitIdle();
    applyStimulus(24'hFFFFFF, 24'hFFFFFF, 24'h800000, 1'b0, 7'h00, 1'b0, 1'b0, 27); waitIdle();
    applyStimulus(24'h000003, 24'h000002, 24'hC00000, 1'b0, 7'h00, 1'b0, 1'b0, 27); waitIdle();
    applyStimulus(24'h400000, 24'h800000, 24'h800000, 1'b0, 7'h7F, 1'b0, 1'b0, 27); waitIdle();

    $display("[TB] in_valid ignored while busy");
    applyStimulus(24'hC00000, 24'h800000, 24'hC00000, 1'b0, 7'h00, 1'b0, 1'b0, 27);
    in_valid = 1'b1; a_mant = 24'h000000; b_mant = 24'h000000;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    waitIdle();

    $display("[TB] output backpressure");
    @(posedge clk); #1 out_ready = 1'b0;
    applyStimulus(24'h800000, 24'hC00000, 24'hAAAAAA, 1'b1, 7'h7F, 1'b0, 1'b0, 27);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("in_ready_after_hs", 32'(in_ready), 32'd1);
    checkOutput("out_valid_after_hs", 32'(out_valid), 32'd0);
    waitIdle();

    $display("[TB] flush during DIV");
    issue(24'h800000, 24'hC00000, acc);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    repeat (30) @(negedge clk);
    applyStimulus(24'h800000, 24'h800000, 24'h800000, 1'b0, 7'h00, 1'b0, 1'b0, 27); waitIdle();

    $display("[TB] reset during DIV");
    issue(24'h000001, 24'h800000, acc);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_mid_q_mant", 32'(q_mant), 32'd0);
    repeat (30) @(negedge clk);
    applyStimulus(24'h800000, 24'h800000, 24'h800000, 1'b0, 7'h00, 1'b0, 1'b0, 27); waitIdle();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
